// File: rtl/ahb_pkg.sv
// Shared AHB encodings and initiator state for the command-to-AHB bridge.
// Holds HTRANS/HBURST/HRESP codes, the FSM state type and the 1 KB region size.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_t;

    // Bursts may not cross a 1 KB address region.
    localparam int KB_BITS = 10;

endpackage

// File: rtl/ahb_verilog_initiator_if.sv
// Command/stream side and AHB side signals of the initiator.
// master: initiator view; slave: the command source plus AHB target view.
interface ahb_verilog_initiator_if #(
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int AHB_WDATA_WIDTH   = 32,
    parameter int AHB_RDATA_WIDTH   = 32
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_write;
    logic [AHB_ADDRESS_WIDTH-1:0] cmd_addr;
    logic [2:0]                   cmd_size;
    logic [4:0]                   cmd_len;
    logic                         wr_pop;
    logic [AHB_WDATA_WIDTH-1:0]   wr_data;
    logic                         rd_valid;
    logic [AHB_RDATA_WIDTH-1:0]   rd_data;
    logic                         rd_last;
    logic                         rd_err;
    logic                         done;
    logic                         done_err;
    logic [AHB_ADDRESS_WIDTH-1:0] HADDR;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic [2:0]                   HSIZE;
    logic [2:0]                   HBURST;
    logic [AHB_WDATA_WIDTH-1:0]   HWDATA;
    logic [AHB_RDATA_WIDTH-1:0]   HRDATA;
    logic                         HREADY;
    logic [1:0]                   HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len,
        input  wr_data, HRDATA, HREADY, HRESP,
        output cmd_ready, wr_pop, rd_valid, rd_data, rd_last, rd_err,
        output done, done_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len,
        output wr_data, HRDATA, HREADY, HRESP,
        input  cmd_ready, wr_pop, rd_valid, rd_data, rd_last, rd_err,
        input  done, done_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

endinterface

// File: rtl/ahb_initiator_addr_gen.sv
// Command sanitising, burst type selection and beat address stepping.
// Ports: raw cmd_* in, cleaned start_* out; cur_addr/cur_size in, next_addr/next_cross out.
module ahb_initiator_addr_gen
    import ahb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_size,
    input  logic [4:0]    cmd_len,
    output logic [AW-1:0] start_addr,
    output logic [2:0]    start_size,
    output logic [4:0]    start_len,
    output hburst_e       start_burst,
    input  logic [AW-1:0] cur_addr,
    input  logic [2:0]    cur_size,
    output logic [AW-1:0] next_addr,
    output logic          next_cross
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));
    localparam logic [4:0] MAX_LEN  = 5'(MAX_BEATS);

    logic [AW-1:0] lsb_mask;
    logic [AW-1:0] span;
    logic [AW-1:0] end_addr;
    logic          same_region;

    always_comb begin
        start_size = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
        if (cmd_len == 5'd0)
            start_len = 5'd1;
        else if (cmd_len > MAX_LEN)
            start_len = MAX_LEN;
        else
            start_len = cmd_len;
    end

    assign lsb_mask   = (AW'(1) << start_size) - AW'(1);
    assign start_addr = cmd_addr & ~lsb_mask;

    // Address of the last byte touched by the whole burst.
    assign span     = AW'(start_len) << start_size;
    assign end_addr = start_addr + span - AW'(1);
    assign same_region =
        end_addr[AW-1:KB_BITS] == start_addr[AW-1:KB_BITS];

    always_comb begin
        start_burst = BURST_INCR;
        unique case (1'b1)
            start_len == 5'd1:
                start_burst = BURST_SINGLE;
            same_region && start_len == 5'd4:
                start_burst = BURST_INCR4;
            same_region && start_len == 5'd8:
                start_burst = BURST_INCR8;
            same_region && start_len == 5'd16:
                start_burst = BURST_INCR16;
            default:
                start_burst = BURST_INCR;
        endcase
    end

    assign next_addr  = cur_addr + (AW'(1) << cur_size);
    assign next_cross =
        next_addr[AW-1:KB_BITS] != cur_addr[AW-1:KB_BITS];

endmodule

// File: rtl/ahb_verilog_initiator.sv
// Single-master AHB initiator: turns one command into a pipelined AHB burst.
// Ports: HCLK, HRESET (async, active high), bus (command, stream and AHB signals).
module ahb_verilog_initiator
    import ahb_pkg::*;
#(
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int AHB_WDATA_WIDTH   = 32,
    parameter int AHB_RDATA_WIDTH   = 32,
    parameter int MAX_BEATS         = 16
) (
    input  logic HCLK,
    input  logic HRESET,
    ahb_verilog_initiator_if.master bus
);
    localparam int AW = AHB_ADDRESS_WIDTH;
    localparam int WW = AHB_WDATA_WIDTH;
    localparam int RW = AHB_RDATA_WIDTH;

    state_t        state_q,    state_d;
    logic [4:0]    left_q,     left_d;
    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic [AW-1:0] haddr_q,    haddr_d;
    htrans_e       htrans_q,   htrans_d;
    logic          hwrite_q,   hwrite_d;
    logic [2:0]    hsize_q,    hsize_d;
    hburst_e       hburst_q,   hburst_d;
    logic [WW-1:0] hwdata_q,   hwdata_d;
    logic          rvalid_q,   rvalid_d;
    logic [RW-1:0] rdata_q,    rdata_d;
    logic          rlast_q,    rlast_d;
    logic          rerr_q,     rerr_d;
    logic          done_q,     done_d;
    logic          derr_q,     derr_d;

    logic [AW-1:0] start_addr;
    logic [2:0]    start_size;
    logic [4:0]    start_len;
    hburst_e       start_burst;
    logic [AW-1:0] next_addr;
    logic          next_cross;
    logic          in_addr;
    logic          resp_err;

    ahb_initiator_addr_gen #(
        .AW        (AW),
        .DW        (WW),
        .MAX_BEATS (MAX_BEATS)
    ) u_addr_gen (
        .cmd_addr    (bus.cmd_addr),
        .cmd_size    (bus.cmd_size),
        .cmd_len     (bus.cmd_len),
        .start_addr  (start_addr),
        .start_size  (start_size),
        .start_len   (start_len),
        .start_burst (start_burst),
        .cur_addr    (haddr_q),
        .cur_size    (hsize_q),
        .next_addr   (next_addr),
        .next_cross  (next_cross)
    );

    assign in_addr  = (state_q == S_ADDR) || (state_q == S_BURST);
    // RETRY and SPLIT share the ERROR path.
    assign resp_err = bus.HRESP != RESP_OKAY;

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        rlast_d    = 1'b0;
        rerr_d     = 1'b0;
        done_d     = 1'b0;
        derr_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    haddr_d    = start_addr;
                    hsize_d    = start_size;
                    hburst_d   = start_burst;
                    hwrite_d   = bus.cmd_write;
                    htrans_d   = TRANS_NONSEQ;
                    left_d     = start_len - 5'd1;
                    dp_valid_d = 1'b0;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR, S_BURST: begin
                if (dp_valid_q && resp_err && !bus.HREADY) begin
                    // Pending address phase was not taken; drop it.
                    htrans_d = TRANS_IDLE;
                    state_d  = S_ERR;
                end else if (bus.HREADY) begin
                    if (dp_valid_q && !dp_write_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = bus.HRDATA;
                    end
                    dp_valid_d = 1'b1;
                    dp_write_d = hwrite_q;
                    if (hwrite_q)
                        hwdata_d = bus.wr_data;
                    if (left_q == 5'd0) begin
                        htrans_d = TRANS_IDLE;
                        state_d  = S_LAST;
                    end else begin
                        left_d  = left_q - 5'd1;
                        haddr_d = next_addr;
                        if (next_cross) begin
                            // New 1 KB region restarts as INCR.
                            htrans_d = TRANS_NONSEQ;
                            hburst_d = BURST_INCR;
                            state_d  = S_ADDR;
                        end else begin
                            htrans_d = TRANS_SEQ;
                            state_d  = S_BURST;
                        end
                    end
                end
            end

            S_LAST: begin
                if (resp_err && !bus.HREADY) begin
                    state_d = S_ERR;
                end else if (bus.HREADY) begin
                    dp_valid_d = 1'b0;
                    if (!dp_write_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = bus.HRDATA;
                        rlast_d  = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_ERR: begin
                if (bus.HREADY) begin
                    dp_valid_d = 1'b0;
                    if (!dp_write_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = bus.HRDATA;
                        rlast_d  = 1'b1;
                        rerr_d   = 1'b1;
                    end
                    done_d  = 1'b1;
                    derr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            left_q     <= '0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            haddr_q    <= '0;
            htrans_q   <= TRANS_IDLE;
            hwrite_q   <= 1'b0;
            hsize_q    <= '0;
            hburst_q   <= BURST_SINGLE;
            hwdata_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rlast_q    <= 1'b0;
            rerr_q     <= 1'b0;
            done_q     <= 1'b0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rlast_q    <= rlast_d;
            rerr_q     <= rerr_d;
            done_q     <= done_d;
            derr_q     <= derr_d;
        end
    end

    // Gated by reset so they drop together with the registered outputs.
    assign bus.cmd_ready = (state_q == S_IDLE) && !HRESET;
    assign bus.wr_pop    = in_addr && hwrite_q && bus.HREADY && !HRESET;

    assign bus.HADDR    = haddr_q;
    assign bus.HTRANS   = htrans_q;
    assign bus.HWRITE   = hwrite_q;
    assign bus.HSIZE    = hsize_q;
    assign bus.HBURST   = hburst_q;
    assign bus.HWDATA   = hwdata_q;
    assign bus.rd_valid = rvalid_q;
    assign bus.rd_data  = rdata_q;
    assign bus.rd_last  = rlast_q;
    assign bus.rd_err   = rerr_q;
    assign bus.done     = done_q;
    assign bus.done_err = derr_q;

endmodule

// File: tb/tb_ahb_verilog_initiator.sv
// Directed bench for ahb_verilog_initiator with a small AHB memory target.
// Covers single, INCR16 with a wait, 1 KB split, ERROR cancel, reset, len edges.
`timescale 1ns/1ps
module tb_ahb_verilog_initiator;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    ahb_verilog_initiator_if #(
        .AHB_ADDRESS_WIDTH (32),
        .AHB_WDATA_WIDTH   (32),
        .AHB_RDATA_WIDTH   (32)
    ) bus ();

    ahb_verilog_initiator #(
        .AHB_ADDRESS_WIDTH (32),
        .AHB_WDATA_WIDTH   (32),
        .AHB_RDATA_WIDTH   (32),
        .MAX_BEATS         (16)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- target memory model ----------------
    logic [31:0] mem [0:1023];
    logic        wrt [0:1023];
    logic        s_act, s_wr, s_stage;
    logic [31:0] s_addr;
    int          s_idx, acc_cnt;
    int          wait_at = -1;
    int          err_at  = -1;
    logic        s_ready;
    logic [1:0]  s_resp;
    logic [31:0] wr_xor = 32'h0;

    always_comb begin
        s_ready = 1'b1;
        s_resp  = 2'b00;
        if (s_act && s_idx == err_at) begin
            s_ready = s_stage;
            s_resp  = 2'b01;
        end else if (s_act && s_idx == wait_at) begin
            s_ready = s_stage;
        end
    end

    assign bus.HREADY  = s_ready;
    assign bus.HRESP   = s_resp;
    assign bus.HRDATA  = (s_act && !s_wr) ?
        (wrt[s_addr[11:2]] ? mem[s_addr[11:2]] : (32'hC0DE0000 | s_addr)) :
        32'h0;
    assign bus.wr_data = wr_xor ^ bus.HADDR;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s_act   <= 1'b0;
            s_wr    <= 1'b0;
            s_stage <= 1'b0;
            s_addr  <= '0;
            s_idx   <= 0;
            acc_cnt <= 0;
            for (int i = 0; i < 1024; i++) wrt[i] <= 1'b0;
        end else if (s_ready) begin
            if (s_act && s_wr && s_resp == 2'b00) begin
                mem[s_addr[11:2]] <= bus.HWDATA;
                wrt[s_addr[11:2]] <= 1'b1;
            end
            s_stage <= 1'b0;
            if (bus.HTRANS[1]) begin
                s_act   <= 1'b1;
                s_addr  <= bus.HADDR;
                s_wr    <= bus.HWRITE;
                s_idx   <= acc_cnt;
                acc_cnt <= acc_cnt + 1;
            end else begin
                s_act <= 1'b0;
            end
        end else begin
            s_stage <= 1'b1;
        end
    end

    // ---------------- monitor ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  t;
        logic [2:0]  b;
        logic [2:0]  s;
    } aph_t;

    aph_t        aq[$];
    logic [31:0] rq_d[$];
    logic        rq_l[$];
    logic        rq_e[$];
    int          cyc = 0;
    int          pops = 0;
    int          dones = 0;
    int          done_cyc = 0;
    logic        last_err = 1'b0;
    logic        err_seen = 1'b0;
    logic [1:0]  err_next_tr = 2'b11;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (bus.HREADY && bus.HTRANS[1])
                aq.push_back({bus.HADDR, bus.HTRANS, bus.HBURST, bus.HSIZE});
            if (bus.wr_pop) pops <= pops + 1;
            if (bus.rd_valid) begin
                rq_d.push_back(bus.rd_data);
                rq_l.push_back(bus.rd_last);
                rq_e.push_back(bus.rd_err);
            end
            if (bus.done) begin
                dones    <= dones + 1;
                done_cyc <= cyc;
                last_err <= bus.done_err;
            end
            if (err_seen) err_next_tr <= bus.HTRANS;
            err_seen <= (bus.HRESP == 2'b01) && !bus.HREADY;
        end
    end

    // ---------------- helpers ----------------
    int tacc, dstart, a0, r0, p0, d0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] ap(input logic [31:0] a,
                                       input logic [1:0] t,
                                       input logic [2:0] b,
                                       input logic [2:0] s);
        return {a, t, b, s};
    endfunction

    task automatic mark();
        a0 = aq.size();
        r0 = rq_d.size();
        p0 = pops;
    endtask

    task automatic send(input logic w, input logic [31:0] a,
                        input logic [2:0] s, input logic [4:0] l);
        int n;
        n = 0;
        @(posedge HCLK); #1;
        dstart        = dones;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_len   = l;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge HCLK); #1;
            n++;
        end
        tacc = cyc;
        @(posedge HCLK); #1;
        bus.cmd_valid = 1'b0;
        if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int lat,
                             input logic exp_err);
        int k;
        k = 0;
        while (dones == dstart && k < 200) begin
            @(posedge HCLK); #1;
            k++;
        end
        chk({tag, "_done"}, 64'(dones - dstart), 64'd1);
        chk({tag, "_lat"}, 64'(done_cyc - tacc), 64'(lat));
        chk({tag, "_derr"}, 64'(last_err), 64'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = '0;
        bus.cmd_len   = '0;

        // reset state
        #1;
        chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("rst_haddr", 64'(bus.HADDR), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        #1 chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // single write then read
        wr_xor = 32'hDEADBEFF;
        mark();
        send(1'b1, 32'h010, 3'd2, 5'd1);
        wait_done("wr1", 3, 1'b0);
        chk("wr1_naph", 64'(aq.size() - a0), 64'd1);
        chk("wr1_aph", 64'(aq[a0]), 64'(ap(32'h010, 2'b10, 3'd0, 3'd2)));
        chk("wr1_pops", 64'(pops - p0), 64'd1);
        mark();
        send(1'b0, 32'h010, 3'd2, 5'd1);
        wait_done("rd1", 3, 1'b0);
        chk("rd1_nrd", 64'(rq_d.size() - r0), 64'd1);
        chk("rd1_data", 64'(rq_d[r0]), 64'hDEADBEEF);
        chk("rd1_last", 64'(rq_l[r0]), 64'd1);
        chk("rd1_err", 64'(rq_e[r0]), 64'd0);
        chk("rd1_burst", 64'(aq[a0].b), 64'd0);

        // INCR16 read with one wait state on the 6th SEQ
        mark();
        wait_at = acc_cnt + 6;
        send(1'b0, 32'h100, 3'd2, 5'd16);
        wait_done("r16", 19, 1'b0);
        wait_at = -1;
        chk("r16_naph", 64'(aq.size() - a0), 64'd16);
        chk("r16_aph0", 64'(aq[a0]), 64'(ap(32'h100, 2'b10, 3'd7, 3'd2)));
        for (int i = 1; i < 16; i++)
            chk($sformatf("r16_aph%0d", i), 64'(aq[a0 + i]),
                64'(ap(32'h100 + 32'(4 * i), 2'b11, 3'd7, 3'd2)));
        chk("r16_nrd", 64'(rq_d.size() - r0), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("r16_d%0d", i), 64'(rq_d[r0 + i]),
                64'(32'hC0DE0100 + 32'(4 * i)));
            chk($sformatf("r16_l%0d", i), 64'(rq_l[r0 + i]),
                64'(i == 15));
        end

        // write across the 0x400 boundary
        wr_xor = 32'h5A5A0000;
        mark();
        send(1'b1, 32'h3F8, 3'd2, 5'd4);
        wait_done("wx", 6, 1'b0);
        chk("wx_naph", 64'(aq.size() - a0), 64'd4);
        chk("wx_aph0", 64'(aq[a0]), 64'(ap(32'h3F8, 2'b10, 3'd1, 3'd2)));
        chk("wx_aph1", 64'(aq[a0+1]), 64'(ap(32'h3FC, 2'b11, 3'd1, 3'd2)));
        chk("wx_aph2", 64'(aq[a0+2]), 64'(ap(32'h400, 2'b10, 3'd1, 3'd2)));
        chk("wx_aph3", 64'(aq[a0+3]), 64'(ap(32'h404, 2'b11, 3'd1, 3'd2)));
        chk("wx_pops", 64'(pops - p0), 64'd4);
        mark();
        send(1'b0, 32'h3FC, 3'd2, 5'd2);
        wait_done("rx", 4, 1'b0);
        chk("rx_d0", 64'(rq_d[r0]), 64'h5A5A03FC);
        chk("rx_d1", 64'(rq_d[r0+1]), 64'h5A5A0400);
        chk("rx_aph1", 64'(aq[a0+1]), 64'(ap(32'h400, 2'b10, 3'd1, 3'd2)));

        // ERROR on beat 3 of an 8-beat read
        mark();
        err_at = acc_cnt + 2;
        send(1'b0, 32'h200, 3'd2, 5'd8);
        wait_done("er", 6, 1'b1);
        err_at = -1;
        chk("er_burst", 64'(aq[a0].b), 64'd5);
        chk("er_naph", 64'(aq.size() - a0), 64'd3);
        chk("er_idle", 64'(err_next_tr), 64'd0);
        chk("er_nrd", 64'(rq_d.size() - r0), 64'd3);
        chk("er_e1", 64'(rq_e[r0+1]), 64'd0);
        chk("er_l1", 64'(rq_l[r0+1]), 64'd0);
        chk("er_e2", 64'(rq_e[r0+2]), 64'd1);
        chk("er_l2", 64'(rq_l[r0+2]), 64'd1);

        // size clamp and address alignment
        mark();
        send(1'b0, 32'h0C6, 3'd3, 5'd1);
        wait_done("sz", 3, 1'b0);
        chk("sz_aph", 64'(aq[a0]), 64'(ap(32'h0C4, 2'b10, 3'd0, 3'd2)));

        // length edges
        mark();
        send(1'b0, 32'h040, 3'd2, 5'd0);
        wait_done("l0", 3, 1'b0);
        chk("l0_naph", 64'(aq.size() - a0), 64'd1);
        chk("l0_burst", 64'(aq[a0].b), 64'd0);
        mark();
        send(1'b0, 32'h080, 3'd2, 5'd20);
        wait_done("l20", 18, 1'b0);
        chk("l20_naph", 64'(aq.size() - a0), 64'd16);
        chk("l20_burst", 64'(aq[a0].b), 64'd7);
        chk("l20_nrd", 64'(rq_d.size() - r0), 64'd16);
        chk("l20_d15", 64'(rq_d[r0+15]), 64'hC0DE00BC);
        chk("l20_l15", 64'(rq_l[r0+15]), 64'd1);

        // reset mid-burst
        send(1'b0, 32'h000, 3'd2, 5'd16);
        repeat (4) @(posedge HCLK);
        #1 HRESET = 1'b1;
        d0 = dones;
        #1;
        chk("mr_htrans", 64'(bus.HTRANS), 64'd0);
        chk("mr_haddr", 64'(bus.HADDR), 64'd0);
        chk("mr_hburst", 64'(bus.HBURST), 64'd0);
        chk("mr_hsize", 64'(bus.HSIZE), 64'd0);
        chk("mr_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("mr_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("mr_wr_pop", 64'(bus.wr_pop), 64'd0);
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        chk("mr_no_done", 64'(dones - d0), 64'd0);
        mark();
        send(1'b1, 32'h020, 3'd2, 5'd1);
        wait_done("pr", 3, 1'b0);
        chk("pr_aph", 64'(aq[a0]), 64'(ap(32'h020, 2'b10, 3'd0, 3'd2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
